// File: rtl/ctrl_cfg_parser.sv
// ctrl_cfg_parser: turns control-packet AXI-Stream beats into per-stage table
// write commands on the cfg_wr_* bus. Beat 0 carries the header (mod_id,
// base_addr, wr_len). Each following payload beat becomes one write of
// tdata[ENTRY_WIDTH-1:0] at base_addr + idx. The stream has no back-pressure,
// so one beat is consumed every cycle.
// Optional feature macro: CFG_STAT_EN builds the good/bad packet counters.
// Without it, cfg_pkt_cnt and cfg_err_cnt are tied to 0.
module ctrl_cfg_parser #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int ENTRY_WIDTH          = 256,
  parameter int ADDR_WIDTH           = 8,
  parameter int MAX_DEPTH            = 256
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic                              cfg_wr_en,
  output logic [7:0]                        cfg_mod_id,
  output logic [ADDR_WIDTH-1:0]             cfg_addr,
  output logic [ENTRY_WIDTH-1:0]            cfg_data,
  output logic [15:0]                       cfg_pkt_cnt,
  output logic [15:0]                       cfg_err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DRAIN} state_t;

  state_t                  state;
  logic [7:0]              mod_id_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [7:0]              len_r;
  logic [7:0]              idx_r;
  logic                    pkt_err_r;

  // Header fields decoded straight off the current beat
  logic [7:0]              hdr_mod_id;
  logic [ADDR_WIDTH-1:0]   hdr_base;
  logic [7:0]              hdr_len;

  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic                    addr_ok;
  logic                    last_entry;
  logic                    pkt_done;
  logic                    pkt_bad;

  // tkeep, tuser and the unused tdata bits are carried only
  logic                    unused_in;
  assign unused_in = ^{c_s_axis_tkeep, c_s_axis_tuser, c_s_axis_tdata};

  assign hdr_mod_id = c_s_axis_tdata[375:368];
  assign hdr_base   = c_s_axis_tdata[384 +: ADDR_WIDTH];
  assign hdr_len    = c_s_axis_tdata[399:392];

  // Address wraps modulo 2^ADDR_WIDTH; anything past the table depth is dropped
  assign wr_addr    = base_r + ADDR_WIDTH'(idx_r);
  assign addr_ok    = (32'(wr_addr) < 32'(MAX_DEPTH));
  assign last_entry = ((idx_r + 8'd1) == len_r);

  // Classify the packet that ends on this beat (tlast) as good or bad
  always_comb begin
    pkt_done = c_s_axis_tvalid && c_s_axis_tlast;
    pkt_bad  = 1'b0;
    case (state)
      S_IDLE:  pkt_bad = (hdr_len != 8'd0);
      S_WRITE: pkt_bad = pkt_err_r || !addr_ok || !last_entry;
      S_DRAIN: pkt_bad = pkt_err_r;
      default: pkt_bad = 1'b0;
    endcase
  end

  // Packet FSM with registered write-command outputs
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      mod_id_r   <= '0;
      base_r     <= '0;
      len_r      <= '0;
      idx_r      <= '0;
      pkt_err_r  <= 1'b0;
      cfg_wr_en  <= 1'b0;
      cfg_mod_id <= '0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
    end else begin
      cfg_wr_en <= 1'b0;
      if (c_s_axis_tvalid) begin
        case (state)
          S_IDLE: begin
            mod_id_r  <= hdr_mod_id;
            base_r    <= hdr_base;
            len_r     <= hdr_len;
            idx_r     <= '0;
            pkt_err_r <= 1'b0;
            if (c_s_axis_tlast)       state <= S_IDLE;
            else if (hdr_len == 8'd0) state <= S_DRAIN;
            else                      state <= S_WRITE;
          end
          S_WRITE: begin
            if (addr_ok) begin
              cfg_wr_en  <= 1'b1;
              cfg_mod_id <= mod_id_r;
              cfg_addr   <= wr_addr;
              cfg_data   <= c_s_axis_tdata[ENTRY_WIDTH-1:0];
            end else begin
              pkt_err_r <= 1'b1;
            end
            idx_r <= idx_r + 8'd1;
            if (c_s_axis_tlast) begin
              state <= S_IDLE;
            end else if (last_entry) begin
              state     <= S_DRAIN;
              pkt_err_r <= 1'b1;
            end
          end
          S_DRAIN: begin
            if (c_s_axis_tlast) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef CFG_STAT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // One counter per finished packet, saturating at all-ones
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_pkt_cnt <= '0;
      cfg_err_cnt <= '0;
    end else if (pkt_done) begin
      if (pkt_bad) cfg_err_cnt <= sat_inc(cfg_err_cnt);
      else         cfg_pkt_cnt <= sat_inc(cfg_pkt_cnt);
    end
  end
`else
  logic unused_stat;
  assign unused_stat = pkt_done ^ pkt_bad;
  assign cfg_pkt_cnt = '0;
  assign cfg_err_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_cfg_parser.sv
// tb_ctrl_cfg_parser: directed bench for ctrl_cfg_parser (MAX_DEPTH=200).
// Expected counter values follow CFG_STAT_EN: counted when defined, 0 otherwise.
module tb_ctrl_cfg_parser;

  localparam int DW  = 512;
  localparam int TUW = 128;
  localparam int EW  = 256;
  localparam int AW  = 8;
`ifdef CFG_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            aresetn;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [TUW-1:0]  tuser;
  logic            tvalid;
  logic            tlast;
  logic            cfg_wr_en;
  logic [7:0]      cfg_mod_id;
  logic [AW-1:0]   cfg_addr;
  logic [EW-1:0]   cfg_data;
  logic [15:0]     cfg_pkt_cnt;
  logic [15:0]     cfg_err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_pkt = 0;
  int exp_err = 0;

  ctrl_cfg_parser #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(TUW),
    .ENTRY_WIDTH         (EW),
    .ADDR_WIDTH          (AW),
    .MAX_DEPTH           (200)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .c_s_axis_tdata (tdata),
    .c_s_axis_tkeep (tkeep),
    .c_s_axis_tuser (tuser),
    .c_s_axis_tvalid(tvalid),
    .c_s_axis_tlast (tlast),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_mod_id     (cfg_mod_id),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .cfg_pkt_cnt    (cfg_pkt_cnt),
    .cfg_err_cnt    (cfg_err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] hdr(input logic [7:0] m, input logic [7:0] b, input logic [7:0] l);
    logic [DW-1:0] d;
    d = '0;
    d[255:0]   = {8{32'hA5A5_0000}};
    d[375:368] = m;
    d[391:384] = b;
    d[399:392] = l;
    return d;
  endfunction

  function automatic logic [EW-1:0] pdat(input logic [31:0] s);
    return {8{s}};
  endfunction

  // Payload beats carry junk in the header byte positions
  function automatic logic [DW-1:0] pay(input logic [31:0] s);
    logic [DW-1:0] d;
    d = {DW{1'b1}};
    d[EW-1:0] = pdat(s);
    return d;
  endfunction

  function automatic logic [15:0] ex(input int n);
    return STAT ? n[15:0] : 16'h0;
  endfunction

  // Present one valid beat, then land #1 after the edge that consumed it
  task automatic beat(input logic [DW-1:0] d, input logic l);
    tdata = d; tlast = l; tvalid = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic idle_cyc();
    tvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++;
    if (cfg_wr_en !== 1'b0 || cfg_mod_id !== 8'h0 || cfg_addr !== 8'h0 || cfg_data !== '0 ||
        cfg_pkt_cnt !== 16'h0 || cfg_err_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs wr_en=%b mod=%h addr=%h pkt=%h err=%h, required all 0",
               cfg_wr_en, cfg_mod_id, cfg_addr, cfg_pkt_cnt, cfg_err_cnt);
    end
  endtask

  task automatic test_good_packet();
    beat(hdr(8'h03, 8'h10, 8'd3), 1'b0);
    checks++;
    if (cfg_wr_en !== 1'b0) begin errors++; $display("FAIL good_hdr_no_strobe wr_en=%b required 0", cfg_wr_en); end
    for (int i = 0; i < 3; i++) begin
      beat(pay(32'h1000_0000 + i), i == 2);
      checks++;
      if (cfg_wr_en !== 1'b1 || cfg_mod_id !== 8'h03 || cfg_addr !== 8'h10 + 8'(i) ||
          cfg_data !== pdat(32'h1000_0000 + i)) begin
        errors++;
        $display("FAIL good_wr%0d wr_en=%b mod=%h addr=%h data=%h required 1 03 %h %h",
                 i, cfg_wr_en, cfg_mod_id, cfg_addr, cfg_data, 8'h10 + 8'(i), pdat(32'h1000_0000 + i));
      end
    end
    exp_pkt++;
    checks++;
    if (cfg_pkt_cnt !== ex(exp_pkt) || cfg_err_cnt !== ex(exp_err)) begin
      errors++; $display("FAIL good_counts pkt=%0d err=%0d required %0d %0d", cfg_pkt_cnt, cfg_err_cnt, ex(exp_pkt), ex(exp_err));
    end
    idle_cyc();
    checks++;
    if (cfg_wr_en !== 1'b0 || cfg_addr !== 8'h12 || cfg_mod_id !== 8'h03 || cfg_data !== pdat(32'h1000_0002)) begin
      errors++; $display("FAIL good_hold wr_en=%b addr=%h mod=%h required 0 12 03", cfg_wr_en, cfg_addr, cfg_mod_id);
    end
  endtask

  task automatic test_runt();
    beat(hdr(8'h05, 8'h20, 8'd4), 1'b0);
    for (int i = 0; i < 2; i++) begin
      beat(pay(32'h2000_0000 + i), i == 1);
      checks++;
      if (cfg_wr_en !== 1'b1 || cfg_mod_id !== 8'h05 || cfg_addr !== 8'h20 + 8'(i) ||
          cfg_data !== pdat(32'h2000_0000 + i)) begin
        errors++;
        $display("FAIL runt_wr%0d wr_en=%b mod=%h addr=%h required 1 05 %h", i, cfg_wr_en, cfg_mod_id, cfg_addr, 8'h20 + 8'(i));
      end
    end
    exp_err++;
    checks++;
    if (cfg_pkt_cnt !== ex(exp_pkt) || cfg_err_cnt !== ex(exp_err)) begin
      errors++; $display("FAIL runt_counts pkt=%0d err=%0d required %0d %0d", cfg_pkt_cnt, cfg_err_cnt, ex(exp_pkt), ex(exp_err));
    end
    // Back in IDLE: the next beat must be taken as a header
    beat(hdr(8'h06, 8'h28, 8'd1), 1'b0);
    checks++;
    if (cfg_wr_en !== 1'b0) begin errors++; $display("FAIL runt_next_hdr wr_en=%b required 0", cfg_wr_en); end
    beat(pay(32'h2800_0000), 1'b1);
    exp_pkt++;
    checks++;
    if (cfg_wr_en !== 1'b1 || cfg_mod_id !== 8'h06 || cfg_addr !== 8'h28 || cfg_pkt_cnt !== ex(exp_pkt)) begin
      errors++; $display("FAIL runt_next_wr wr_en=%b mod=%h addr=%h pkt=%0d required 1 06 28 %0d",
                         cfg_wr_en, cfg_mod_id, cfg_addr, cfg_pkt_cnt, ex(exp_pkt));
    end
  endtask

  task automatic test_overlong();
    beat(hdr(8'h07, 8'h30, 8'd1), 1'b0);
    beat(pay(32'h3000_0000), 1'b0);
    checks++;
    if (cfg_wr_en !== 1'b1 || cfg_addr !== 8'h30 || cfg_mod_id !== 8'h07 || cfg_data !== pdat(32'h3000_0000)) begin
      errors++; $display("FAIL overlong_wr wr_en=%b addr=%h mod=%h required 1 30 07", cfg_wr_en, cfg_addr, cfg_mod_id);
    end
    for (int i = 1; i < 3; i++) begin
      beat(pay(32'h3000_0000 + i), i == 2);
      checks++;
      if (cfg_wr_en !== 1'b0 || cfg_addr !== 8'h30) begin
        errors++; $display("FAIL overlong_drain%0d wr_en=%b addr=%h required 0 30", i, cfg_wr_en, cfg_addr);
      end
    end
    exp_err++;
    checks++;
    if (cfg_pkt_cnt !== ex(exp_pkt) || cfg_err_cnt !== ex(exp_err)) begin
      errors++; $display("FAIL overlong_counts pkt=%0d err=%0d required %0d %0d", cfg_pkt_cnt, cfg_err_cnt, ex(exp_pkt), ex(exp_err));
    end
    beat(hdr(8'h08, 8'h40, 8'd2), 1'b0);
    for (int i = 0; i < 2; i++) begin
      beat(pay(32'h4000_0000 + i), i == 1);
      checks++;
      if (cfg_wr_en !== 1'b1 || cfg_mod_id !== 8'h08 || cfg_addr !== 8'h40 + 8'(i) || cfg_data !== pdat(32'h4000_0000 + i)) begin
        errors++; $display("FAIL overlong_next_wr%0d wr_en=%b mod=%h addr=%h required 1 08 %h", i, cfg_wr_en, cfg_mod_id, cfg_addr, 8'h40 + 8'(i));
      end
    end
    exp_pkt++;
    checks++;
    if (cfg_pkt_cnt !== ex(exp_pkt) || cfg_err_cnt !== ex(exp_err)) begin
      errors++; $display("FAIL overlong_next_counts pkt=%0d err=%0d required %0d %0d", cfg_pkt_cnt, cfg_err_cnt, ex(exp_pkt), ex(exp_err));
    end
  endtask

  task automatic test_depth_limit();
    beat(hdr(8'h09, 8'hC6, 8'd4), 1'b0);
    for (int i = 0; i < 4; i++) begin
      beat(pay(32'h5000_0000 + i), i == 3);
      checks++;
      if (i < 2) begin
        if (cfg_wr_en !== 1'b1 || cfg_addr !== 8'hC6 + 8'(i) || cfg_mod_id !== 8'h09 || cfg_data !== pdat(32'h5000_0000 + i)) begin
          errors++; $display("FAIL depth_wr%0d wr_en=%b addr=%h required 1 %h", i, cfg_wr_en, cfg_addr, 8'hC6 + 8'(i));
        end
      end else begin
        if (cfg_wr_en !== 1'b0 || cfg_addr !== 8'hC7 || cfg_data !== pdat(32'h5000_0001)) begin
          errors++; $display("FAIL depth_suppress%0d wr_en=%b addr=%h required 0 c7", i, cfg_wr_en, cfg_addr);
        end
      end
    end
    exp_err++;
    checks++;
    if (cfg_pkt_cnt !== ex(exp_pkt) || cfg_err_cnt !== ex(exp_err)) begin
      errors++; $display("FAIL depth_counts pkt=%0d err=%0d required %0d %0d", cfg_pkt_cnt, cfg_err_cnt, ex(exp_pkt), ex(exp_err));
    end
  endtask

  task automatic test_valid_gaps();
    beat(hdr(8'h0A, 8'h50, 8'd2), 1'b0);
    for (int i = 0; i < 2; i++) begin
      idle_cyc();
      checks++;
      if (cfg_wr_en !== 1'b0) begin errors++; $display("FAIL gap_idle%0d wr_en=%b required 0", i, cfg_wr_en); end
      beat(pay(32'h6000_0000 + i), i == 1);
      checks++;
      if (cfg_wr_en !== 1'b1 || cfg_addr !== 8'h50 + 8'(i) || cfg_mod_id !== 8'h0A || cfg_data !== pdat(32'h6000_0000 + i)) begin
        errors++; $display("FAIL gap_wr%0d wr_en=%b addr=%h required 1 %h", i, cfg_wr_en, cfg_addr, 8'h50 + 8'(i));
      end
    end
    idle_cyc();
    exp_pkt++;
    checks++;
    if (cfg_wr_en !== 1'b0 || cfg_pkt_cnt !== ex(exp_pkt) || cfg_err_cnt !== ex(exp_err)) begin
      errors++; $display("FAIL gap_end wr_en=%b pkt=%0d err=%0d required 0 %0d %0d", cfg_wr_en, cfg_pkt_cnt, cfg_err_cnt, ex(exp_pkt), ex(exp_err));
    end
  endtask

  task automatic test_zero_len();
    beat(hdr(8'h01, 8'h00, 8'd0), 1'b1);
    exp_pkt++;
    checks++;
    if (cfg_wr_en !== 1'b0 || cfg_pkt_cnt !== ex(exp_pkt) || cfg_err_cnt !== ex(exp_err)) begin
      errors++; $display("FAIL zero_single wr_en=%b pkt=%0d err=%0d required 0 %0d %0d", cfg_wr_en, cfg_pkt_cnt, cfg_err_cnt, ex(exp_pkt), ex(exp_err));
    end
    beat(hdr(8'h02, 8'h00, 8'd0), 1'b0);
    beat(pay(32'h7000_0000), 1'b0);
    checks++;
    if (cfg_wr_en !== 1'b0) begin errors++; $display("FAIL zero_drain wr_en=%b required 0", cfg_wr_en); end
    beat(pay(32'h7000_0001), 1'b1);
    exp_pkt++;
    checks++;
    if (cfg_wr_en !== 1'b0 || cfg_pkt_cnt !== ex(exp_pkt) || cfg_err_cnt !== ex(exp_err)) begin
      errors++; $display("FAIL zero_multi wr_en=%b pkt=%0d err=%0d required 0 %0d %0d", cfg_wr_en, cfg_pkt_cnt, cfg_err_cnt, ex(exp_pkt), ex(exp_err));
    end
  endtask

  task automatic test_reset_mid_packet();
    beat(hdr(8'h0B, 8'h60, 8'd3), 1'b0);
    beat(pay(32'h8000_0000), 1'b0);
    checks++;
    if (cfg_wr_en !== 1'b1 || cfg_addr !== 8'h60) begin
      errors++; $display("FAIL rst_pre_wr wr_en=%b addr=%h required 1 60", cfg_wr_en, cfg_addr);
    end
    #1 aresetn = 1'b0;
    #1;
    checks++;
    if (cfg_wr_en !== 1'b0 || cfg_mod_id !== 8'h0 || cfg_addr !== 8'h0 || cfg_data !== '0 ||
        cfg_pkt_cnt !== 16'h0 || cfg_err_cnt !== 16'h0) begin
      errors++; $display("FAIL rst_async wr_en=%b mod=%h addr=%h pkt=%0d err=%0d required all 0",
                         cfg_wr_en, cfg_mod_id, cfg_addr, cfg_pkt_cnt, cfg_err_cnt);
    end
    @(posedge clk); #1;
    aresetn = 1'b1;
    exp_pkt = 0;
    exp_err = 0;
    beat(hdr(8'h0C, 8'h70, 8'd1), 1'b0);
    checks++;
    if (cfg_wr_en !== 1'b0) begin errors++; $display("FAIL rst_new_hdr wr_en=%b required 0", cfg_wr_en); end
    beat(pay(32'h9000_0000), 1'b1);
    exp_pkt++;
    checks++;
    if (cfg_wr_en !== 1'b1 || cfg_mod_id !== 8'h0C || cfg_addr !== 8'h70 || cfg_data !== pdat(32'h9000_0000) ||
        cfg_pkt_cnt !== ex(exp_pkt) || cfg_err_cnt !== ex(exp_err)) begin
      errors++; $display("FAIL rst_new_wr wr_en=%b mod=%h addr=%h pkt=%0d err=%0d required 1 0c 70 %0d %0d",
                         cfg_wr_en, cfg_mod_id, cfg_addr, cfg_pkt_cnt, cfg_err_cnt, ex(exp_pkt), ex(exp_err));
    end
  endtask

  initial begin
    aresetn = 1'b0;
    tdata   = '0;
    tkeep   = '1;
    tuser   = '0;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    aresetn = 1'b1;
    idle_cyc();
    test_good_packet();
    test_runt();
    test_overlong();
    test_depth_limit();
    test_valid_gaps();
    test_zero_len();
    test_reset_mid_packet();
    idle_cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
